// File: rtl/float_pkg.sv
// rtl/float_pkg.sv - shared types and constants for the floating-point multiply pipeline
package float_pkg;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fclass_t;

  localparam int FLAG_W         = 4;
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  // Quiet NaN: sign 0, exponent all ones, fraction MSB set; callers truncate to their width.
  function automatic logic [127:0] canonical_nan(input int exp_w, input int man_w);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < exp_w; i++) r[man_w+i] = 1'b1;
    r[man_w-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/float_unpack.sv
// rtl/float_unpack.sv - splits an operand into sign, exponent, significand and class
module float_unpack
  import float_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] op,
  output logic                 sign,
  output logic [EXP_W-1:0]     expo,
  output logic [MAN_W:0]       sig,
  output fclass_t              cls
);

  logic [MAN_W-1:0] frac;

  assign sign = op[EXP_W+MAN_W];
  assign expo = op[EXP_W+MAN_W-1:MAN_W];
  assign frac = op[MAN_W-1:0];
  assign sig  = {1'b1, frac};

  // Denormals classify as zero, which flushes them.
  always_comb begin
    cls = CLS_NORM;
    if (expo == '0) cls = CLS_ZERO;
    else if (&expo) cls = (frac == '0) ? CLS_INF : CLS_NAN;
  end

endmodule

// File: rtl/float_mul_pipe.sv
// rtl/float_mul_pipe.sv - pipelined floating-point multiplier with RNE rounding and exception flags
module float_mul_pipe
  import float_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_data,
  output logic [FLAG_W-1:0]      out_flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int SW   = MAN_W + 1;
  localparam int PW   = 2 * SW;
  localparam int EW   = EXP_W + 2;
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;

  localparam logic [W-1:0]         QNAN     = W'(canonical_nan(EXP_W, MAN_W));
  localparam logic signed [EW-1:0] BIAS_S   = EW'(BIAS);
  localparam logic signed [EW-1:0] EXP_MAX  = EW'(2 ** EXP_W - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;

  logic advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Stage 1: captured operands
  logic         s1_valid;
  logic [W-1:0] s1_a, s1_b;

  logic             ua_sign, ub_sign;
  logic [EXP_W-1:0] ua_expo, ub_expo;
  logic [MAN_W:0]   ua_sig, ub_sig;
  fclass_t          ua_cls, ub_cls;
  logic signed [EW-1:0] exp_sum;

  float_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
    .op(s1_a), .sign(ua_sign), .expo(ua_expo), .sig(ua_sig), .cls(ua_cls)
  );
  float_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
    .op(s1_b), .sign(ub_sign), .expo(ub_expo), .sig(ub_sig), .cls(ub_cls)
  );

  assign exp_sum = $signed({2'b00, ua_expo}) + $signed({2'b00, ub_expo}) - BIAS_S;

  // Stage 2: unpacked operands
  logic                 s2_valid;
  logic                 s2_sign;
  logic signed [EW-1:0] s2_exp;
  logic [SW-1:0]        s2_sig_a, s2_sig_b;
  fclass_t              s2_cls_a, s2_cls_b;
  logic [PW-1:0]        prod;

  assign prod = {{SW{1'b0}}, s2_sig_a} * {{SW{1'b0}}, s2_sig_b};

  // Stage 3: raw significand product
  logic                 s3_valid;
  logic                 s3_sign;
  logic signed [EW-1:0] s3_exp;
  logic [PW-1:0]        s3_prod;
  fclass_t              s3_cls_a, s3_cls_b;

  logic [PW-1:0]        norm;
  logic signed [EW-1:0] exp_n, exp_f;
  logic [MAN_W-1:0]     frac_t;
  logic [MAN_W:0]       frac_r;
  logic                 guard, sticky, inc;
  logic                 a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [W-1:0]         res_data;
  logic [FLAG_W-1:0]    res_flags;

  always_comb begin
    norm   = s3_prod[PW-1] ? s3_prod : (s3_prod << 1);
    exp_n  = s3_exp + $signed({{(EW-1){1'b0}}, s3_prod[PW-1]});
    frac_t = norm[PW-2 -: MAN_W];
    guard  = norm[MAN_W];
    sticky = |norm[MAN_W-1:0];
    inc    = guard & (sticky | frac_t[0]);
    // A rounding carry leaves the fraction field all zeros and bumps the exponent.
    frac_r = {1'b0, frac_t} + {{MAN_W{1'b0}}, inc};
    exp_f  = exp_n + $signed({{(EW-1){1'b0}}, frac_r[MAN_W]});

    a_nan  = (s3_cls_a == CLS_NAN);
    b_nan  = (s3_cls_b == CLS_NAN);
    a_inf  = (s3_cls_a == CLS_INF);
    b_inf  = (s3_cls_b == CLS_INF);
    a_zero = (s3_cls_a == CLS_ZERO);
    b_zero = (s3_cls_b == CLS_ZERO);

    res_flags = '0;
    if (a_nan || b_nan) begin
      res_data = QNAN;
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      res_data                = QNAN;
      res_flags[FLAG_INVALID] = 1'b1;
    end else if (a_inf || b_inf) begin
      res_data = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      res_data = {s3_sign, {(W-1){1'b0}}};
    end else if (exp_f >= EXP_MAX) begin
      res_data                 = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      res_flags[FLAG_OVERFLOW] = 1'b1;
      res_flags[FLAG_INEXACT]  = 1'b1;
    end else if (exp_f <= EXP_ZERO) begin
      res_data                  = {s3_sign, {(W-1){1'b0}}};
      res_flags[FLAG_UNDERFLOW] = 1'b1;
      res_flags[FLAG_INEXACT]   = 1'b1;
    end else begin
      res_data                = {s3_sign, exp_f[EXP_W-1:0], frac_r[MAN_W-1:0]};
      res_flags[FLAG_INEXACT] = guard | sticky;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      s3_valid  <= s2_valid;
      out_valid <= s3_valid;
      if (s3_valid) begin
        out_data  <= res_data;
        out_flags <= res_flags;
      end
    end
  end

  // Datapath registers load only with a valid entry, so bubbles leave them untouched.
  always_ff @(posedge clk) begin
    if (advance) begin
      if (in_valid) begin
        s1_a <= in_a;
        s1_b <= in_b;
      end
      if (s1_valid) begin
        s2_sign  <= ua_sign ^ ub_sign;
        s2_exp   <= exp_sum;
        s2_sig_a <= ua_sig;
        s2_sig_b <= ub_sig;
        s2_cls_a <= ua_cls;
        s2_cls_b <= ub_cls;
      end
      if (s2_valid) begin
        s3_sign  <= s2_sign;
        s3_exp   <= s2_exp;
        s3_prod  <= prod;
        s3_cls_a <= s2_cls_a;
        s3_cls_b <= s2_cls_b;
      end
    end
  end

endmodule

// File: tb/tb_float_mul_pipe.sv
// tb/tb_float_mul_pipe.sv - self-checking bench for float_mul_pipe (binary32 configuration)
module tb_float_mul_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_a = '0, in_b = '0;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_flags;

  int n_vec  = 0;
  int n_fail = 0;
  logic [35:0] exp_q[$];
  logic [35:0] got_q[$];

  float_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  // Exact integer product, rounded to 24 significant bits by division-style remainder test.
  function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int     ea, eb, e, k, sh;
    longint ma, mb, p, q, rem, half;
    logic   sign, inexact, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [31:0] r;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    sign   = a[31] ^ b[31];
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if (a_nan || b_nan) return {32'h7FC00000, 4'b0000};
    if ((a_inf && b_zero) || (b_inf && a_zero)) return {32'h7FC00000, 4'b1000};
    if (a_inf || b_inf) return {sign, 8'hFF, 23'h0, 4'b0000};
    if (a_zero || b_zero) return {sign, 31'h0, 4'b0000};
    ma = longint'(a[22:0]) + (64'sd1 <<< 23);
    mb = longint'(b[22:0]) + (64'sd1 <<< 23);
    p  = ma * mb;
    k  = (p >= (64'sd1 <<< 47)) ? 47 : 46;
    sh = k - 23;
    q    = p >>> sh;
    rem  = p - (q <<< sh);
    half = 64'sd1 <<< (sh - 1);
    inexact = (rem != 0);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    e = ea + eb - 127 + (k - 46);
    if (q == (64'sd1 <<< 24)) begin
      q = q >>> 1;
      e = e + 1;
    end
    if (e >= 255) return {sign, 8'hFF, 23'h0, 4'b0101};
    if (e <= 0) return {sign, 31'h0, 4'b0011};
    r = {sign, e[7:0], q[22:0]};
    return {r, 3'b000, inexact};
  endfunction

  function automatic logic [31:0] gen_operand();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 3) != 0) v[30:23] = 8'($urandom_range(100, 154));
    if ($urandom_range(0, 31) == 0) v[30:23] = 8'd0;
    if ($urandom_range(0, 31) == 0) v[30:23] = 8'hFF;
    if ($urandom_range(0, 63) == 0) v[22:0] = 23'd0;
    return v;
  endfunction

  // Drives one cycle of stimulus and records accepted inputs and delivered outputs.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic rdy, output logic acc);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    out_ready = rdy;
    #1;
    acc = v && in_ready && !rst;
    if (acc) exp_q.push_back(ref_mul(a, b));
    if (out_valid && out_ready && !rst) got_q.push_back({out_data, out_flags});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic acc;
    rst = 1'b1;
    cycle(1'b0, '0, '0, 1'b0, acc);
    cycle(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, acc);
    rst = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_vec++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00000000", out_data); end
    n_vec++; if (out_flags !== 4'h0) begin n_fail++; $display("FAIL reset_out_flags: got %b expected 0000", out_flags); end
    n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_directed();
    logic [31:0] va[10], vb[10], vr[10];
    logic [3:0]  vf[10];
    logic        acc;
    int          lat;
    va[0] = 32'h3FC00000; vb[0] = 32'h40000000; vr[0] = 32'h40400000; vf[0] = 4'b0000;
    va[1] = 32'h3F800001; vb[1] = 32'h3F800001; vr[1] = 32'h3F800002; vf[1] = 4'b0001;
    va[2] = 32'h3F800001; vb[2] = 32'h3FC00000; vr[2] = 32'h3FC00002; vf[2] = 4'b0001;
    va[3] = 32'h7F000000; vb[3] = 32'h7F000000; vr[3] = 32'h7F800000; vf[3] = 4'b0101;
    va[4] = 32'h00800000; vb[4] = 32'h00800000; vr[4] = 32'h00000000; vf[4] = 4'b0011;
    va[5] = 32'h7F800000; vb[5] = 32'h00000000; vr[5] = 32'h7FC00000; vf[5] = 4'b1000;
    va[6] = 32'hFF800000; vb[6] = 32'h40000000; vr[6] = 32'hFF800000; vf[6] = 4'b0000;
    va[7] = 32'h7FC00001; vb[7] = 32'h3F800000; vr[7] = 32'h7FC00000; vf[7] = 4'b0000;
    va[8] = 32'h00000001; vb[8] = 32'hBF800000; vr[8] = 32'h80000000; vf[8] = 4'b0000;
    va[9] = 32'hC0400000; vb[9] = 32'h40A00000; vr[9] = 32'hC1700000; vf[9] = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, va[i], vb[i], 1'b1, acc);
      n_vec++; if (acc !== 1'b1) begin n_fail++; $display("FAIL dir%0d_accept: got %b expected 1", i, acc); end
      lat = 0;
      while (!out_valid && lat < 10) begin
        cycle(1'b0, '0, '0, 1'b0, acc);
        lat++;
      end
      n_vec++; if (lat != 3) begin n_fail++; $display("FAIL dir%0d_latency: got %0d expected 3", i, lat); end
      n_vec++; if (out_data !== vr[i]) begin n_fail++; $display("FAIL dir%0d_data: got %h expected %h", i, out_data, vr[i]); end
      n_vec++; if (out_flags !== vf[i]) begin n_fail++; $display("FAIL dir%0d_flags: got %b expected %b", i, out_flags, vf[i]); end
      cycle(1'b0, '0, '0, 1'b1, acc);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_random();
    logic acc;
    int   n;
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, gen_operand(), gen_operand(), $urandom_range(0, 3) != 0, acc);
    for (int i = 0; i < 60 && got_q.size() < exp_q.size(); i++) cycle(1'b0, '0, '0, 1'b1, acc);
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_count: got %0d results expected %0d", got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand%0d: got %h/%b expected %h/%b", i, got_q[i][35:4], got_q[i][3:0],
                 exp_q[i][35:4], exp_q[i][3:0]);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_back_to_back();
    logic        acc, rdy;
    logic [31:0] held;
    int          sent;
    sent = 0;
    held = '0;
    for (int t = 0; t < 30; t++) begin
      rdy = !(t >= 4 && t < 9);
      if (t == 4) held = out_data;
      if (t > 4 && t <= 9) begin
        n_vec++; if (out_data !== held) begin n_fail++; $display("FAIL stall_hold_t%0d: got %h expected %h", t, out_data, held); end
      end
      if (!rdy && out_valid) begin
        out_ready = 1'b0;
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready_t%0d: got %b expected 0", t, in_ready); end
      end
      cycle(sent < 6, gen_operand(), gen_operand(), rdy, acc);
      if (acc) sent++;
    end
    n_vec++; if (got_q.size() != 6) begin n_fail++; $display("FAIL bp_count: got %0d expected 6", got_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL bp%0d: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset_inflight();
    logic acc;
    int   seen;
    for (int i = 0; i < 3; i++) cycle(1'b1, gen_operand(), gen_operand(), 1'b1, acc);
    rst = 1'b1;
    cycle(1'b1, gen_operand(), gen_operand(), 1'b1, acc);
    rst = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_fly_out_valid: got %b expected 0", out_valid); end
    n_vec++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL rst_fly_out_data: got %h expected 00000000", out_data); end
    n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_fly_in_ready: got %b expected 1", in_ready); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      cycle(1'b0, '0, '0, 1'b1, acc);
    end
    n_vec++; if (seen != 0) begin n_fail++; $display("FAIL rst_fly_stale: got %0d results expected 0", seen); end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
